// File: rtl/spi_pkg.sv
// Shared types, length codes and helpers for the SPI transaction queue.
package spi_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 2;

    // Transaction length codes understood by spi_master
    localparam logic [LEN_W-1:0] LEN_8  = 2'b00;
    localparam logic [LEN_W-1:0] LEN_16 = 2'b01;
    localparam logic [LEN_W-1:0] LEN_24 = 2'b10;
    localparam logic [LEN_W-1:0] LEN_32 = 2'b11;

    // Launch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LAUNCH    = 2'b01,
        ST_WAIT_BUSY = 2'b10,
        ST_WAIT_DONE = 2'b11
    } state_t;

    // Mask selecting the right-aligned bits that are valid for a length code
    function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [DATA_W-1:0] m;
        case (len)
            LEN_8:   m = 32'h0000_00FF;
            LEN_16:  m = 32'h0000_FFFF;
            LEN_24:  m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/count.
module spi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push_c = push & ~full;
    assign do_pop_c  = pop & ~empty;
    // Head entry is presented directly; zero when nothing is stored
    assign rd_data   = empty ? '0 : mem[rd_ptr];

    // Storage array, written on accepted push only
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_transaction_queue.sv
// Buffers SPI requests, launches them one at a time on spi_master and
// returns each received word, tagged with its slave address.
module spi_transaction_queue
    import spi_pkg::*;
#(
    parameter int unsigned SLAVE_COUNT = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT     = 4,
    localparam int unsigned AW         = $clog2(SLAVE_COUNT),
    localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [AW-1:0]     req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [AW-1:0]     rsp_addr,
    output logic              spi_start,
    input  logic              spi_busy,
    output logic [DATA_W-1:0] spi_tx_data,
    output logic [AW-1:0]     spi_addr,
    output logic [LEN_W-1:0]  spi_len,
    input  logic [DATA_W-1:0] spi_rx_data,
    output logic              err_timeout,
    output logic [CW-1:0]     pending
);

    localparam int unsigned TCW = $clog2(TIMEOUT + 1);
    localparam int unsigned CMD_W = DATA_W + AW + LEN_W;
    localparam int unsigned RSP_W = DATA_W + AW;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AW-1:0]     addr;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AW-1:0]     addr;
    } rsp_t;

    cmd_t           cmd_wr;
    cmd_t           cmd_rd;
    rsp_t           rsp_wr;
    rsp_t           rsp_rd;
    logic           cmd_full;
    logic           cmd_empty;
    logic           rsp_full;
    logic           rsp_empty;
    logic [CW-1:0]  rsp_level_unused;
    logic           req_fire_c;
    logic           rsp_fire_c;

    state_t         state;
    state_t         state_next;
    logic [TCW-1:0] to_cnt;
    logic           cmd_pop_c;
    logic           rsp_push_c;
    logic           load_c;
    logic           cnt_clr_c;
    logic           cnt_inc_c;
    logic           err_set_c;

    assign req_ready  = ~cmd_full;
    assign req_fire_c = req_valid & req_ready;
    assign rsp_valid  = ~rsp_empty;
    assign rsp_fire_c = rsp_valid & rsp_ready;
    assign rsp_data   = rsp_rd.data;
    assign rsp_addr   = rsp_rd.addr;

    assign cmd_wr = '{data: req_data, addr: req_addr, len: req_len};
    // Received word trimmed to the launched length, tagged with its slave
    assign rsp_wr = '{data: spi_rx_data & len_mask(spi_len), addr: spi_addr};

    spi_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_fire_c),
        .wr_data (cmd_wr),
        .pop     (cmd_pop_c),
        .rd_data (cmd_rd),
        .full    (cmd_full),
        .empty   (cmd_empty),
        .count   (pending)
    );

    spi_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rsp_push_c),
        .wr_data (rsp_wr),
        .pop     (rsp_fire_c),
        .rd_data (rsp_rd),
        .full    (rsp_full),
        .empty   (rsp_empty),
        .count   (rsp_level_unused)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next state and per-cycle control strobes
    always_comb begin
        state_next = state;
        cmd_pop_c  = 1'b0;
        rsp_push_c = 1'b0;
        load_c     = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        err_set_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Launch only when a result slot is guaranteed
                if (~cmd_empty & ~rsp_full & ~spi_busy) begin
                    cmd_pop_c  = 1'b1;
                    load_c     = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_clr_c  = 1'b1;
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (to_cnt == TCW'(TIMEOUT - 1)) begin
                    // Master never acknowledged: drop the command
                    err_set_c  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (~spi_busy) begin
                    rsp_push_c = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Start pulse registered so it is high exactly while in LAUNCH
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_start <= 1'b0;
        end else begin
            spi_start <= (state_next == ST_LAUNCH);
        end
    end

    // Holding registers feeding the master, loaded only on the IDLE pop
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_tx_data <= '0;
            spi_addr    <= '0;
            spi_len     <= '0;
        end else if (load_c) begin
            spi_tx_data <= cmd_rd.data;
            spi_addr    <= cmd_rd.addr;
            spi_len     <= cmd_rd.len;
        end
    end

    // Start-to-busy timeout counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (cnt_clr_c) begin
                to_cnt <= '0;
            end else if (cnt_inc_c) begin
                to_cnt <= to_cnt + TCW'(1);
            end
            if (err_set_c) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_transaction_queue.sv
// Directed bench for spi_transaction_queue with a behavioural spi_master model.
module tb_spi_transaction_queue;
    import spi_pkg::*;

    localparam int unsigned SLAVE_COUNT = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned TIMEOUT     = 4;
    localparam int unsigned AW          = 3;
    localparam int unsigned CW          = 3;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_data;
    logic [AW-1:0]     req_addr;
    logic [1:0]        req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [AW-1:0]     rsp_addr;
    logic              spi_start;
    logic              spi_busy;
    logic [31:0]       spi_tx_data;
    logic [AW-1:0]     spi_addr;
    logic [1:0]        spi_len;
    logic [31:0]       spi_rx_data;
    logic              err_timeout;
    logic [CW-1:0]     pending;

    int tests = 0;
    int fails = 0;

    spi_transaction_queue #(
        .SLAVE_COUNT (SLAVE_COUNT),
        .DEPTH       (DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_addr    (rsp_addr),
        .spi_start   (spi_start),
        .spi_busy    (spi_busy),
        .spi_tx_data (spi_tx_data),
        .spi_addr    (spi_addr),
        .spi_len     (spi_len),
        .spi_rx_data (spi_rx_data),
        .err_timeout (err_timeout),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- spi_master model ----------------
    logic        hold_busy    = 1'b0;
    logic        no_busy      = 1'b0;
    int          busy_len     = 3;
    logic [31:0] reply_key    = 32'h0;
    logic        m_busy       = 1'b0;
    int          m_cnt        = 0;
    logic [31:0] m_tx         = 32'h0;
    logic [AW-1:0] m_addr     = '0;
    logic [1:0]  m_len        = 2'b00;
    int          launches     = 0;
    logic        start_prev   = 1'b0;
    logic        double_start = 1'b0;
    logic        tx_unstable  = 1'b0;

    assign spi_busy = m_busy | hold_busy;

    // Busy for busy_len cycles after a start; reply = tx ^ reply_key when busy drops
    always @(posedge clk) begin
        if (rst) begin
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            spi_rx_data <= 32'h0;
            start_prev  <= 1'b0;
        end else begin
            start_prev <= spi_start;
            if (spi_start && start_prev) double_start <= 1'b1;
            if (spi_start) begin
                launches <= launches + 1;
                m_tx     <= spi_tx_data;
                m_addr   <= spi_addr;
                m_len    <= spi_len;
            end
            if (spi_start && !no_busy && !m_busy) begin
                m_busy      <= 1'b1;
                m_cnt       <= busy_len;
                spi_rx_data <= 32'hBAD0_BAD0;
            end else if (m_busy) begin
                if (spi_tx_data !== m_tx) tx_unstable <= 1'b1;
                if (m_cnt <= 1) begin
                    m_busy      <= 1'b0;
                    spi_rx_data <= spi_tx_data ^ reply_key;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [AW-1:0] a, input logic [1:0] l,
                        input int bound, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = d;
        req_addr  = a;
        req_len   = l;
        for (int i = 0; i < bound && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input int bound, output logic [31:0] d, output logic [AW-1:0] a,
                           output bit ok);
        ok = 1'b0;
        d  = 32'hX;
        a  = 'X;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                d = rsp_data;
                a = rsp_addr;
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
                ok = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] addr;
        logic [1:0]    len;
        logic [31:0]   key;
        int            blen;
        logic [31:0]   exp_data;
    } vec_t;

    vec_t          vecs [6];
    bit            ok;
    logic [31:0]   got_d;
    logic [AW-1:0] got_a;
    int            l0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_00A5, 3'd3, LEN_8,  32'hFFFF_FF99, 2, 32'h0000_003C};
        vecs[1] = '{32'h0000_1234, 3'd5, LEN_16, 32'h0F0F_0F0F, 4, 32'h0000_1D3B};
        vecs[2] = '{32'h00AB_CDEF, 3'd7, LEN_24, 32'h1111_1111, 1, 32'h00BA_DCFE};
        vecs[3] = '{32'hDEAD_BEEF, 3'd0, LEN_32, 32'hFFFF_FFFF, 6, 32'h2152_4110};
        vecs[4] = '{32'h0000_0000, 3'd1, LEN_8,  32'h0000_0080, 3, 32'h0000_0080};
        vecs[5] = '{32'hFFFF_FFFF, 3'd6, LEN_16, 32'h0000_FFFF, 2, 32'h0000_0000};

        rst = 1'b1; req_valid = 1'b0; req_data = '0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_tx_data", spi_tx_data, 0);
        check("rst_spi_addr", spi_addr, 0);
        check("rst_spi_len", spi_len, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_pending", pending, 0);
        rst = 1'b0;

        // Single 8-bit request: launch latency and response timing
        reply_key = 32'hFFFF_FF99; busy_len = 3; l0 = launches;
        send(32'h0000_00A5, 3'd3, LEN_8, 20, ok);
        check("lat_accept", ok, 1);
        @(negedge clk);
        check("lat_no_start_yet", spi_start, 0);
        check("lat_pending_1", pending, 1);
        @(negedge clk);
        check("lat_start_high", spi_start, 1);
        check("lat_tx_data", spi_tx_data, 32'hA5);
        check("lat_spi_addr", spi_addr, 3);
        check("lat_pending_0", pending, 0);
        @(negedge clk);
        check("lat_start_low", spi_start, 0);
        check("lat_busy_high", spi_busy, 1);
        for (int i = 0; i < 20 && spi_busy; i++) @(negedge clk);
        check("lat_busy_fell", spi_busy, 0);
        check("lat_rsp_not_yet", rsp_valid, 0);
        @(negedge clk);
        check("lat_rsp_valid", rsp_valid, 1);
        get_rsp(20, got_d, got_a, ok);
        check("lat_rsp_ok", ok, 1);
        check("lat_rsp_data", got_d, 32'h3C);
        check("lat_rsp_addr", got_a, 3);
        check("lat_one_launch", launches - l0, 1);

        // Table of length/data/address combinations
        for (int v = 0; v < 6; v++) begin
            reply_key = vecs[v].key;
            busy_len  = vecs[v].blen;
            send(vecs[v].data, vecs[v].addr, vecs[v].len, 20, ok);
            check($sformatf("vec%0d_accept", v), ok, 1);
            get_rsp(60, got_d, got_a, ok);
            check($sformatf("vec%0d_rsp_ok", v), ok, 1);
            check($sformatf("vec%0d_tx", v), m_tx, vecs[v].data);
            check($sformatf("vec%0d_spi_addr", v), m_addr, vecs[v].addr);
            check($sformatf("vec%0d_spi_len", v), m_len, vecs[v].len);
            check($sformatf("vec%0d_rsp_data", v), got_d, vecs[v].exp_data);
            check($sformatf("vec%0d_rsp_addr", v), got_a, vecs[v].addr);
        end

        // Master stalled busy: command FIFO fills at DEPTH
        reply_key = 32'h0000_0F00; busy_len = 2;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h10 + i, AW'(i + 2), LEN_8, 10, ok);
            check($sformatf("stall_accept%0d", i), ok, 1);
        end
        @(negedge clk);
        check("stall_req_ready_low", req_ready, 0);
        check("stall_pending_4", pending, 4);
        send(32'h99, 3'd1, LEN_8, 5, ok);
        check("stall_5th_refused", ok, 0);
        @(negedge clk);
        hold_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_rsp(80, got_d, got_a, ok);
            check($sformatf("stall_rsp%0d_ok", i), ok, 1);
            check($sformatf("stall_rsp%0d_data", i), got_d, 32'h10 + i);
            check($sformatf("stall_rsp%0d_addr", i), got_a, i + 2);
        end
        @(negedge clk);
        check("stall_drained_rsp", rsp_valid, 0);

        // Response FIFO full gates launching
        reply_key = 32'h0; busy_len = 2; l0 = launches;
        for (int i = 0; i < 6; i++) begin
            send(32'h20 + i, AW'(i), LEN_8, 100, ok);
            check($sformatf("bp_accept%0d", i), ok, 1);
        end
        repeat (80) @(negedge clk);
        check("bp_four_launches", launches - l0, 4);
        check("bp_pending_2", pending, 2);
        check("bp_rsp_valid", rsp_valid, 1);
        get_rsp(5, got_d, got_a, ok);
        check("bp_rsp0_data", got_d, 32'h20);
        for (int i = 0; i < 40 && (launches - l0) < 5; i++) @(negedge clk);
        check("bp_resumed", launches - l0, 5);
        for (int i = 1; i < 6; i++) begin
            get_rsp(80, got_d, got_a, ok);
            check($sformatf("bp_rsp%0d_ok", i), ok, 1);
            check($sformatf("bp_rsp%0d_data", i), got_d, 32'h20 + i);
            check($sformatf("bp_rsp%0d_addr", i), got_a, i);
        end

        // Master never answers: timeout after 4 waiting cycles
        no_busy = 1'b1;
        send(32'h99, 3'd1, LEN_8, 20, ok);
        check("to_accept", ok, 1);
        repeat (6) @(negedge clk);
        check("to_not_yet", err_timeout, 0);
        @(negedge clk);
        check("to_err_set", err_timeout, 1);
        no_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("to_no_rsp", rsp_valid, 0);
        check("to_pending_0", pending, 0);
        reply_key = 32'h0000_0100; busy_len = 3;
        send(32'hC3, 3'd2, LEN_8, 20, ok);
        get_rsp(60, got_d, got_a, ok);
        check("to_next_ok", ok, 1);
        check("to_next_data", got_d, 32'hC3);
        check("to_next_addr", got_a, 2);
        check("to_err_sticky", err_timeout, 1);

        // Reset while a transaction is in WAIT_DONE
        reply_key = 32'h0; busy_len = 3;
        send(32'h55, 3'd2, LEN_8, 20, ok);
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        busy_len = 12;
        send(32'h66, 3'd4, LEN_8, 20, ok);
        for (int i = 0; i < 20 && !spi_busy; i++) @(negedge clk);
        send(32'h77, 3'd5, LEN_8, 20, ok);
        @(negedge clk);
        check("mid_pre_pending", pending, 1);
        check("mid_pre_rsp_valid", rsp_valid, 1);
        check("mid_pre_busy", spi_busy, 1);
        rst = 1'b1;
        l0 = launches;
        @(negedge clk);
        check("mid_req_ready", req_ready, 1);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_rsp_data", rsp_data, 0);
        check("mid_rsp_addr", rsp_addr, 0);
        check("mid_spi_start", spi_start, 0);
        check("mid_spi_tx_data", spi_tx_data, 0);
        check("mid_spi_addr", spi_addr, 0);
        check("mid_spi_len", spi_len, 0);
        check("mid_err_timeout", err_timeout, 0);
        check("mid_pending", pending, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_no_launch", launches - l0, 0);
        check("mid_no_rsp", rsp_valid, 0);
        busy_len = 2;
        send(32'h0000_00F0, 3'd6, LEN_16, 20, ok);
        get_rsp(60, got_d, got_a, ok);
        check("post_rst_ok", ok, 1);
        check("post_rst_data", got_d, 32'hF0);
        check("post_rst_addr", got_a, 6);

        check("start_single_cycle", double_start, 0);
        check("tx_stable_in_busy", tx_unstable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
